serial_sign_magnitude_decoder: RTL and testbench



---
 rtl/twos_pkg.sv | 13 +
 rtl/twos_bit_cell.sv | 28 ++
 rtl/serial_sign_magnitude_decoder.sv | 102 ++++++++++
 tb/tb_serial_sign_magnitude_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/twos_pkg.sv
// Definitions shared by the bit-serial two's-complement encoder and decoder:
// the FSM state encoding and the default word width.
package twos_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/twos_bit_cell.sv
// Serial copy-until-first-one-then-invert cell. It remembers whether a 1 has
// already passed and, for negative operands, inverts every later bit.
module twos_bit_cell (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    input  logic Negative,
    input  logic Bit_In,
    output logic Bit_Out
);

    logic r_seen_one;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_seen_one <= 1'b0;
        end else if (Clear) begin
            r_seen_one <= 1'b0;
        end else if (Enable) begin
            r_seen_one <= r_seen_one | Bit_In;
        end
    end

    // The first 1 itself passes unchanged; only bits after it are inverted.
    assign Bit_Out = (Negative & r_seen_one) ? ~Bit_In : Bit_In;

endmodule

// File: rtl/serial_sign_magnitude_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit
// per clock, with a Start/Busy/Done handshake.
module serial_sign_magnitude_decoder
    import twos_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_In,
    output logic             Busy,
    output logic             Done,
    output logic             Sign,
    output logic [WIDTH-1:0] Magnitude
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_sign;
    logic             w_accept;
    logic             w_shift_en;
    logic             w_last;
    logic             w_bit_out;

    assign w_accept   = (r_state == IDLE) && Start;
    assign w_shift_en = (r_state == SHIFT);
    assign w_last     = w_shift_en && (r_cnt == CW'(WIDTH - 1));

    twos_bit_cell u_cell (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (w_accept),
        .Enable   (w_shift_en),
        .Negative (r_sign),
        .Bit_In   (r_shift[0]),
        .Bit_Out  (w_bit_out)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start)  w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shift  <= '0;
            r_result <= '0;
            r_mag    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sign   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift <= Data_In;
                r_sign  <= Data_In[WIDTH-1];
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (w_shift_en) begin
                // Result fills from the MSB side so the first bit ends at bit 0.
                r_shift  <= r_shift >> 1;
                r_result <= {w_bit_out, r_result[WIDTH-1:1]};
                if (!w_last) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (r_state == DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_mag  <= r_result;
            end
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Sign      = r_sign;
    assign Magnitude = r_mag;

endmodule

// File: tb/tb_serial_sign_magnitude_decoder.sv
// Scoreboard bench: the driver pushes the expected sign/magnitude and accept
// cycle of each conversion; a negedge monitor checks Busy and every Done.
module tb_serial_sign_magnitude_decoder;

    typedef struct {
        int         acc;
        logic       sign;
        logic [7:0] mag;
    } exp_t;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       Start4 = 1'b0;
    logic       Start8 = 1'b0;
    logic [3:0] Data4  = '0;
    logic [7:0] Data8  = '0;
    logic       Busy4, Done4, Sign4;
    logic [3:0] Mag4;
    logic       Busy8, Done8, Sign8;
    logic [7:0] Mag8;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q8[$];

    serial_sign_magnitude_decoder #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .Data_In(Data4),
        .Busy(Busy4), .Done(Done4), .Sign(Sign4), .Magnitude(Mag4)
    );

    serial_sign_magnitude_decoder #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Start(Start8), .Data_In(Data8),
        .Busy(Busy8), .Done(Done8), .Sign(Sign8), .Magnitude(Mag8)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: interpret the low w bits as a signed integer and take |x|.
    function automatic void ref_model(input int w, input logic [7:0] v,
                                      output logic s, output logic [7:0] m);
        int x;
        x = int'(v) & ((1 << w) - 1);
        if (x >= (1 << (w - 1))) x = x - (1 << w);
        s = (x < 0);
        m = 8'((x < 0) ? -x : x);
    endfunction

    task automatic mon(input bit big, input logic busy, input logic done,
                       input logic sign, input logic [7:0] mag);
        int   w;
        bit   have;
        exp_t f;
        w    = big ? 8 : 4;
        have = big ? (q8.size() > 0) : (q4.size() > 0);
        if (have) f = big ? q8[0] : q4[0];
        chk(big ? "busy8" : "busy4", 32'(busy),
            32'(have && cyc >= f.acc && cyc <= f.acc + w));
        if (done) begin
            if (!have) begin
                chk(big ? "spurious_done8" : "spurious_done4", 32'(done), 32'd0);
            end else begin
                chk(big ? "latency8" : "latency4", 32'(cyc), 32'(f.acc + w + 1));
                chk(big ? "sign8" : "sign4", 32'(sign), 32'(f.sign));
                chk(big ? "mag8" : "mag4", 32'(mag), 32'(f.mag));
                if (big) void'(q8.pop_front()); else void'(q4.pop_front());
            end
        end else if (have && cyc >= f.acc + w + 1) begin
            chk(big ? "missing_done8" : "missing_done4", 32'(done), 32'd1);
            if (big) void'(q8.pop_front()); else void'(q4.pop_front());
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            mon(1'b0, Busy4, Done4, Sign4, {4'b0, Mag4});
            mon(1'b1, Busy8, Done8, Sign8, Mag8);
        end
    end

    task automatic accept(input bit big, input logic [7:0] v);
        exp_t e;
        if (big) begin Start8 = 1'b1; Data8 = v; end
        else     begin Start4 = 1'b1; Data4 = v[3:0]; end
        @(posedge Clk); #1;
        e.acc = cyc;
        ref_model(big ? 8 : 4, v, e.sign, e.mag);
        if (big) q8.push_back(e); else q4.push_back(e);
    endtask

    // One full conversion; Start and Data_In toggle randomly while busy.
    task automatic conv(input bit big, input logic [7:0] v);
        accept(big, v);
        repeat ((big ? 8 : 4) + 1) begin
            if (big) begin Start8 = 1'($urandom); Data8 = 8'($urandom); end
            else     begin Start4 = 1'($urandom); Data4 = 4'($urandom); end
            @(posedge Clk); #1;
        end
        Start4 = 1'b0;
        Start8 = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy4"}, 32'(Busy4), 32'd0);
        chk({tag, "_done4"}, 32'(Done4), 32'd0);
        chk({tag, "_sign4"}, 32'(Sign4), 32'd0);
        chk({tag, "_mag4"},  32'(Mag4),  32'd0);
        chk({tag, "_busy8"}, 32'(Busy8), 32'd0);
        chk({tag, "_mag8"},  32'(Mag8),  32'd0);
    endtask

    initial begin
        logic [7:0] dir [5];
        dir = '{8'h0A, 8'h05, 8'h00, 8'h08, 8'h0F};

        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        foreach (dir[i]) conv(1'b0, dir[i]);

        // Start held high; Data_In changes mid-conversion and the second
        // conversion is accepted the cycle after Done.
        accept(1'b0, 8'h0A);
        repeat (2) begin @(posedge Clk); #1; end
        Data4 = 4'b0011;
        repeat (3) begin @(posedge Clk); #1; end
        accept(1'b0, 8'h03);
        Start4 = 1'b0;
        repeat (5) begin @(posedge Clk); #1; end

        // Asynchronous reset in the middle of a shift.
        accept(1'b0, 8'h0A);
        Start4 = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 chk_zero("midreset");
        q4.delete();
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
        conv(1'b0, 8'h0E);

        for (int v = 0; v < 16; v++) conv(1'b0, 8'(v));
        repeat (30) conv(1'b0, 8'($urandom));

        conv(1'b1, 8'h80);
        conv(1'b1, 8'h7F);
        conv(1'b1, 8'hFF);
        conv(1'b1, 8'h00);
        repeat (10) conv(1'b1, 8'($urandom));

        repeat (20) @(posedge Clk);
        #1;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
